// File: rtl/pc_sequencer.sv
// Bus initiator for the PC storage register: read-increment-write or direct jump write.
// Optional read-back verification is compiled in with `define PC_SEQ_VERIFY_EN.
module pc_sequencer #(
    parameter int WORD_SIZE = 4,
    parameter int STEP      = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req,
    input  logic                 i_jump,
    input  logic [WORD_SIZE-1:0] i_jump_addr,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [WORD_SIZE-1:0] o_pc,
    output logic                 o_wrap,
    output logic                 o_err,
    output logic                 o_cs,
    output logic                 o_we,
    output logic                 o_oe,
    output logic [WORD_SIZE-1:0] o_bus_data,
    input  logic [WORD_SIZE-1:0] i_bus_data,
    output logic [2:0]           o_state
);

    // Handshake: i_req / i_jump are taken only on an edge where o_busy is low;
    // anything presented while busy is dropped and must be re-issued by the requester.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_VRD  = 3'd5;
    localparam logic [2:0] S_VCAP = 3'd6;

    localparam logic [WORD_SIZE:0] STEP_EXT = (WORD_SIZE + 1)'(STEP);

    logic [2:0]           state_q, state_d;
    logic [WORD_SIZE-1:0] next_q, next_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic                 wrap_q, wrap_d;
    logic [WORD_SIZE:0]   sum;
`ifdef PC_SEQ_VERIFY_EN
    logic                 err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        next_d  = next_q;
        pc_d    = pc_q;
        wrap_d  = wrap_q;
`ifdef PC_SEQ_VERIFY_EN
        err_d   = err_q;
`endif
        // Carry-out of the extended sum is the wrap indication.
        sum     = {1'b0, i_bus_data} + STEP_EXT;
        case (state_q)
            S_IDLE: begin
                if (i_jump) begin
                    next_d  = i_jump_addr;
                    wrap_d  = 1'b0;
`ifdef PC_SEQ_VERIFY_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_WR;
                end else if (i_req) begin
`ifdef PC_SEQ_VERIFY_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_RD;
                end
            end
            S_RD:  state_d = S_CAP;
            S_CAP: begin
                next_d  = sum[WORD_SIZE-1:0];
                wrap_d  = sum[WORD_SIZE];
                state_d = S_WR;
            end
            S_WR: begin
`ifdef PC_SEQ_VERIFY_EN
                state_d = S_VRD;
`else
                pc_d    = next_q;
                state_d = S_DONE;
`endif
            end
`ifdef PC_SEQ_VERIFY_EN
            S_VRD: state_d = S_VCAP;
            S_VCAP: begin
                err_d   = (i_bus_data != next_q);
                pc_d    = next_q;
                state_d = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            next_q  <= '0;
            pc_q    <= '0;
            wrap_q  <= 1'b0;
`ifdef PC_SEQ_VERIFY_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            next_q  <= next_d;
            pc_q    <= pc_d;
            wrap_q  <= wrap_d;
`ifdef PC_SEQ_VERIFY_EN
            err_q   <= err_d;
`endif
        end
    end

    // All outputs decode registered state so reset drops the bus immediately.
    assign o_busy     = (state_q != S_IDLE);
    assign o_done     = (state_q == S_DONE);
    assign o_pc       = pc_q;
    assign o_wrap     = (state_q == S_DONE) && wrap_q;
    assign o_cs       = (state_q == S_RD) || (state_q == S_WR) || (state_q == S_VRD);
    assign o_we       = (state_q == S_WR);
    assign o_oe       = (state_q == S_RD) || (state_q == S_VRD);
    assign o_bus_data = (state_q == S_WR) ? next_q : '0;
    assign o_state    = state_q;
`ifdef PC_SEQ_VERIFY_EN
    assign o_err      = (state_q == S_DONE) && err_q;
`else
    assign o_err      = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural PC storage register on its bus.
module tb_pc_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WR   = 3'd3;
`ifdef PC_SEQ_VERIFY_EN
    localparam int INC_LAT = 6;
    localparam int JMP_LAT = 4;
`else
    localparam int INC_LAT = 4;
    localparam int JMP_LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       i_req, i_jump;
    logic [3:0] i_jump_addr;
    logic       o_busy, o_done, o_wrap, o_err, o_cs, o_we, o_oe;
    logic [3:0] o_pc, o_bus_data, i_bus_data;
    logic [2:0] o_state;

    // register model
    logic [3:0] reg_mem, rdata, load_val;
    logic       load_en, corrupt;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.WORD_SIZE(4), .STEP(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(i_req), .i_jump(i_jump),
        .i_jump_addr(i_jump_addr), .o_busy(o_busy), .o_done(o_done),
        .o_pc(o_pc), .o_wrap(o_wrap), .o_err(o_err), .o_cs(o_cs),
        .o_we(o_we), .o_oe(o_oe), .o_bus_data(o_bus_data),
        .i_bus_data(i_bus_data), .o_state(o_state)
    );

    always @(posedge clk) begin
        if (load_en) reg_mem <= load_val;
        else if (o_cs && o_we) reg_mem <= corrupt ? (o_bus_data ^ 4'h1) : o_bus_data;
        if (o_cs && o_oe) rdata <= reg_mem;
    end
    assign i_bus_data = rdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] v);
        load_val = v;
        load_en  = 1'b1;
        tick();
        load_en  = 1'b0;
    endtask

    task automatic accept(input logic req, input logic jump, input logic [3:0] addr);
        i_req       = req;
        i_jump      = jump;
        i_jump_addr = addr;
        tick();
        i_req       = 1'b0;
        i_jump      = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (o_done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_req = 1'b0; i_jump = 1'b0; i_jump_addr = 4'h0;
        load_en = 1'b0; load_val = 4'h0; corrupt = 1'b0;
        #12;
        chk_cnt++;
        if ({o_busy, o_done, o_wrap, o_err, o_cs, o_we, o_oe} !== 7'b0 ||
            o_pc !== 4'h0 || o_bus_data !== 4'h0 || o_state !== S_IDLE)
            $display("FAIL reset_state: ctl=%b pc=%h bus=%h state=%0d, want all 0",
                     {o_busy, o_done, o_wrap, o_err, o_cs, o_we, o_oe}, o_pc, o_bus_data, o_state);
        else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_increment();
        preload(4'h5);
        accept(1'b1, 1'b0, 4'h0);
        chk_cnt++;
        if ({o_cs, o_oe, o_we, o_busy} !== 4'b1101 || o_state !== S_RD)
            $display("FAIL inc_rd: cs/oe/we/busy=%b state=%0d, want 1101 state=%0d",
                     {o_cs, o_oe, o_we, o_busy}, o_state, S_RD);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({o_cs, o_oe, o_we} !== 3'b000)
            $display("FAIL inc_cap: cs/oe/we=%b, want 000", {o_cs, o_oe, o_we});
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({o_cs, o_oe, o_we} !== 3'b101 || o_bus_data !== 4'h6)
            $display("FAIL inc_wr: cs/oe/we=%b data=%h, want 101 data=6", {o_cs, o_oe, o_we}, o_bus_data);
        else pass_cnt++;
`ifdef PC_SEQ_VERIFY_EN
        tick();
        chk_cnt++;
        if ({o_cs, o_oe, o_we} !== 3'b110)
            $display("FAIL inc_vrd: cs/oe/we=%b, want 110", {o_cs, o_oe, o_we});
        else pass_cnt++;
        tick();
`endif
        tick();
        chk_cnt++;
        if (o_done !== 1'b1 || o_pc !== 4'h6 || o_wrap !== 1'b0 || o_err !== 1'b0 || o_bus_data !== 4'h0)
            $display("FAIL inc_done: done=%b pc=%h wrap=%b err=%b bus=%h, want 1 6 0 0 0",
                     o_done, o_pc, o_wrap, o_err, o_bus_data);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_pc !== 4'h6 || reg_mem !== 4'h6)
            $display("FAIL inc_after: done=%b busy=%b pc=%h reg=%h, want 0 0 6 6",
                     o_done, o_busy, o_pc, reg_mem);
        else pass_cnt++;
    endtask

    task automatic test_busy_drop();
        int  lat;
        bit  saw_busy;
        accept(1'b1, 1'b0, 4'h0);
        i_req = 1'b1;
        tick();
        i_req = 1'b0;
        wait_done(lat);
        lat++;
        chk_cnt++;
        if (lat !== INC_LAT || o_pc !== 4'h7)
            $display("FAIL drop_op: latency=%0d pc=%h, want %0d 7", lat, o_pc, INC_LAT);
        else pass_cnt++;
        saw_busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (o_busy !== 1'b0) saw_busy = 1'b1;
        end
        chk_cnt++;
        if (saw_busy !== 1'b0 || reg_mem !== 4'h7)
            $display("FAIL drop_no_second: busy_seen=%b reg=%h, want 0 7", saw_busy, reg_mem);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        int lat;
        preload(4'hF);
        accept(1'b1, 1'b0, 4'h0);
        wait_done(lat);
        chk_cnt++;
        if (lat !== INC_LAT || o_pc !== 4'h0 || o_wrap !== 1'b1)
            $display("FAIL wrap: latency=%0d pc=%h wrap=%b, want %0d 0 1", lat, o_pc, o_wrap, INC_LAT);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (o_wrap !== 1'b0 || reg_mem !== 4'h0)
            $display("FAIL wrap_after: wrap=%b reg=%h, want 0 0", o_wrap, reg_mem);
        else pass_cnt++;
    endtask

    task automatic test_priority();
        int lat;
        accept(1'b1, 1'b1, 4'hA);
        chk_cnt++;
        if (o_state !== S_WR || {o_cs, o_oe, o_we} !== 3'b101 || o_bus_data !== 4'hA)
            $display("FAIL prio_wr: state=%0d cs/oe/we=%b data=%h, want %0d 101 a",
                     o_state, {o_cs, o_oe, o_we}, o_bus_data, S_WR);
        else pass_cnt++;
        wait_done(lat);
        chk_cnt++;
        if (lat !== JMP_LAT || o_pc !== 4'hA || o_wrap !== 1'b0)
            $display("FAIL prio_done: latency=%0d pc=%h wrap=%b, want %0d a 0", lat, o_pc, o_wrap, JMP_LAT);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_abort();
        bit saw_done;
        accept(1'b0, 1'b1, 4'h3);
        chk_cnt++;
        if (o_we !== 1'b1 || o_bus_data !== 4'h3)
            $display("FAIL abort_wr: we=%b data=%h, want 1 3", o_we, o_bus_data);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        chk_cnt++;
        if (o_cs !== 1'b0 || o_we !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 ||
            o_pc !== 4'h0 || o_state !== S_IDLE)
            $display("FAIL abort_reset: cs=%b we=%b busy=%b done=%b pc=%h state=%0d, want 0 0 0 0 0 0",
                     o_cs, o_we, o_busy, o_done, o_pc, o_state);
        else pass_cnt++;
        tick();
        #2 rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (o_done !== 1'b0) saw_done = 1'b1;
        end
        chk_cnt++;
        if (saw_done !== 1'b0 || reg_mem !== 4'hA || o_pc !== 4'h0)
            $display("FAIL abort_after: done_seen=%b reg=%h pc=%h, want 0 a 0", saw_done, reg_mem, o_pc);
        else pass_cnt++;
    endtask

`ifdef PC_SEQ_VERIFY_EN
    task automatic test_verify();
        int lat;
        preload(4'h5);
        corrupt = 1'b1;
        accept(1'b1, 1'b0, 4'h0);
        wait_done(lat);
        chk_cnt++;
        if (lat !== 6 || o_err !== 1'b1 || o_pc !== 4'h6)
            $display("FAIL verify_bad: latency=%0d err=%b pc=%h, want 6 1 6", lat, o_err, o_pc);
        else pass_cnt++;
        tick();
        corrupt = 1'b0;
        preload(4'h5);
        accept(1'b1, 1'b0, 4'h0);
        wait_done(lat);
        chk_cnt++;
        if (lat !== 6 || o_err !== 1'b0 || o_pc !== 4'h6)
            $display("FAIL verify_good: latency=%0d err=%b pc=%h, want 6 0 6", lat, o_err, o_pc);
        else pass_cnt++;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_increment();
        test_busy_drop();
        test_wrap();
        test_priority();
        test_reset_abort();
`ifdef PC_SEQ_VERIFY_EN
        test_verify();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Bus initiator that drives a single-word program-counter register through its chip-select / write-enable / output-enable interface. On request, it either reads the stored PC, adds a fixed step and writes the result back, or writes a jump target directly. It then reports the new PC to the fetch logic. It sits between the fetch control and the PC storage register and is the only master of that register's bus.

## Interface
Parameters:
- WORD_SIZE, 4, PC width in bits
- STEP, 1, increment added on a normal advance; must be < 2^WORD_SIZE

Ports:
- i_clk  in  1  clock, all state changes on rising edge
- i_rst  in  1  reset; asynchronous, active-high
- i_req  in  1  advance request (increment), sampled only in IDLE
- i_jump  in  1  jump request, sampled only in IDLE; wins over i_req
- i_jump_addr  in  WORD_SIZE  jump target, sampled with i_jump
- o_busy  out  1  high whenever state ≠ IDLE
- o_done  out  1  one-cycle pulse: PC update complete
- o_pc  out  WORD_SIZE  last PC written; held between operations
- o_wrap  out  1  pulses with o_done when the increment overflowed
- o_err  out  1  pulses with o_done on read-back mismatch (see Configuration)
- o_cs  out  1  register chip select
- o_we  out  1  register write enable
- o_oe  out  1  register output enable
- o_bus_data  out  WORD_SIZE  write data to register
- i_bus_data  in  WORD_SIZE  read data from register

## Operation
- Moore FSM; all outputs decoded from registered state and data registers, no combinational input→output path.
- States: IDLE, RD, CAP, WR, DONE (plus VRD, VCAP when verify is compiled in).
- IDLE: bus controls 0. i_jump=1 → latch i_jump_addr as next, go to WR. Otherwise i_req=1 → RD. Otherwise stay.
- RD: o_cs=1, o_oe=1, o_we=0 for exactly one cycle → CAP.
- CAP: bus idle. At the edge, next = (i_bus_data + STEP) mod 2^WORD_SIZE. Latch wrap flag = carry-out → WR.
- WR: o_cs=1, o_we=1, o_oe=0, o_bus_data=next for one cycle → DONE (or VRD).
- DONE: o_done=1. o_pc updated to next at the entry edge. o_wrap = latched wrap flag (always 0 for jumps) → IDLE.
- o_bus_data = 0 outside WR.
- Requests arriving while o_busy=1 are dropped, not queued. The fetch side must hold or re-issue them.
- i_req and i_jump both high in IDLE → jump only. No read is performed.

## Timing
- Reset (async, immediate): state IDLE. o_cs, o_we, o_oe, o_busy, o_done, o_wrap, o_err = 0. o_pc = 0, o_bus_data = 0, next = 0, wrap flag = 0.
- Reset during WR aborts the write: o_cs/o_we fall with i_rst, not at the next edge.
- Let E be the acceptance edge.
- Increment: RD in cycle E..E+1. Register returns data after edge E+1, and the sequencer samples it at edge E+2. WR in cycle E+2..E+3. o_done high in cycle E+3..E+4. Latency: 4 cycles, next acceptance at E+4 at the earliest.
- Jump: WR in cycle E..E+1. o_done high in cycle E+1..E+2. Latency: 2 cycles.
- o_busy rises at E and falls at the edge ending DONE.

## Configuration
- PC_SEQ_VERIFY_EN defined:
  - After WR the FSM goes VRD (cs=1, oe=1, one cycle) → VCAP, where it compares i_bus_data against next, then → DONE.
  - On mismatch, o_err=1 during DONE.
  - Adds 2 cycles to both paths: increment 6, jump 4.
- Not defined: no VRD/VCAP states and o_err is tied to 0.

## Test plan
- Reset: assert i_rst mid-simulation → all outputs 0 immediately, o_pc=0, o_busy=0.
- Increment: register model holds 5, pulse i_req → RD one cycle, WR with o_bus_data=6. o_done in 4th cycle after acceptance, o_pc=6, o_wrap=0.
- Wrap: WORD_SIZE=4, register holds 15, STEP=1 → writes 0, o_pc=0, o_wrap=1 with o_done.
- Priority: i_req=1 and i_jump=1 with i_jump_addr=4'hA in IDLE → no RD cycle, WR of 4'hA. o_done 2 cycles after acceptance.
- Busy drop and reset abort: pulse i_req during RD → no second operation. Assert i_rst during WR → o_cs/o_we drop the same cycle, FSM in IDLE, no o_done.
- Verify (PC_SEQ_VERIFY_EN): register model corrupts the write (stores 7 instead of 6) → o_err=1 with o_done, latency 6. Correct model → o_err=0.
